// File: rtl/run_controller.sv
// ============================================================================
// Module      : run_controller
// Description : Single-step / free-run / breakpoint controller that drives a
//               registered processor clock enable. Four-state FSM (IDLE, STEP,
//               RUN, BRK), RUN prescaler, saturating enable counter and an
//               optional PC stall watchdog.
// Config      : Define RUN_CONTROLLER_WATCHDOG_EN to build the stall watchdog.
//               When undefined, no watchdog logic is built and Stalled is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_controller #(
    parameter int PC_WIDTH   = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int RUN_DIV    = 4,
    parameter int WDOG_LIMIT = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 StepStrobe,
    input  logic                 RunToggle,
    input  logic                 BreakEn,
    input  logic [PC_WIDTH-1:0]  BreakAddr,
    input  logic [PC_WIDTH-1:0]  PC,
    input  logic                 Halted,
    output logic                 ProcEnable,
    output logic [1:0]           Mode,
    output logic [CNT_WIDTH-1:0] CycleCount,
    output logic                 Stalled
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_STEP = 2'b01;
    localparam logic [1:0] c_ST_RUN  = 2'b10;
    localparam logic [1:0] c_ST_BRK  = 2'b11;

    // Prescaler is 8 bits wide: RUN_DIV is limited to 1..255.
    localparam int              c_PRESC_W    = 8;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(RUN_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);

    // Reject parameter values the datapath cannot represent.
    generate
        if ((RUN_DIV < 1) || (RUN_DIV > 255)) begin : g_bad_run_div
            $error("run_controller: RUN_DIV must be in 1..255");
        end
        if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
            $error("run_controller: WDOG_LIMIT must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_pulse_next;
    logic [c_PRESC_W-1:0] w_presc_next;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_proc_enable;
    logic                 r_issued;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_bp_hit;
    logic                 w_wdog_trip;

    // The breakpoint is only armed once a pulse has actually completed in
    // this RUN session, so resuming from a break at the breakpoint PC does
    // not immediately re-break before the processor has moved on.
    assign w_bp_hit = BreakEn && (PC == BreakAddr) && r_issued;

    // ------------------------------------------------------------------------
    // Optional stall watchdog
    // ------------------------------------------------------------------------
`ifdef RUN_CONTROLLER_WATCHDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);

    logic [PC_WIDTH-1:0] r_pulse_pc;  // PC seen while the last pulse was high
    logic                r_check;     // cycle after a pulse: result visible
    logic [c_WDOG_W-1:0] r_same_cnt;  // consecutive pulses that left PC alone
    logic                r_stalled;

    // A pulse "left PC unchanged" when the PC one cycle after the pulse still
    // equals the PC seen during the pulse. Trip on the WDOG_LIMIT-th such pulse.
    assign w_wdog_trip = (r_state == c_ST_RUN) && r_check &&
                         (PC == r_pulse_pc) && (r_same_cnt == c_WDOG_LAST);

    // Track consecutive no-progress pulses; history is discarded outside RUN.
    always_ff @(posedge Clock) begin
        if (Reset || (w_next_state != c_ST_RUN)) begin
            r_pulse_pc <= '0;
            r_check    <= 1'b0;
            r_same_cnt <= '0;
        end else begin
            r_check <= (r_state == c_ST_RUN) && r_proc_enable;
            if (r_proc_enable) begin
                r_pulse_pc <= PC;
            end
            if (r_check) begin
                r_same_cnt <= (PC == r_pulse_pc) ? (r_same_cnt + c_WDOG_ONE) : '0;
            end
        end
    end

    // Stall flag: set when the watchdog forces BRK, cleared when BRK is left.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stalled <= 1'b0;
        end else if (w_wdog_trip && (w_next_state == c_ST_BRK)) begin
            r_stalled <= 1'b1;
        end else if ((r_state == c_ST_BRK) && (w_next_state != c_ST_BRK)) begin
            r_stalled <= 1'b0;
        end
    end

    assign Stalled = r_stalled;
`else
    assign w_wdog_trip = 1'b0;
    assign Stalled     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; RUN exits are checked in priority order.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_BRK: begin
                if (Halted) begin
                    w_next_state = c_ST_BRK;
                end else if (RunToggle) begin
                    w_next_state = c_ST_RUN;
                end else if (StepStrobe) begin
                    w_next_state = c_ST_STEP;
                end
            end
            c_ST_STEP: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_RUN: begin
                if (RunToggle) begin
                    w_next_state = c_ST_IDLE;
                end else if (Halted) begin
                    w_next_state = c_ST_BRK;
                end else if (w_bp_hit) begin
                    w_next_state = c_ST_BRK;
                end else if (w_wdog_trip) begin
                    w_next_state = c_ST_BRK;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Output logic: decide whether the coming cycle carries an enable pulse.
    // Because ProcEnable is registered from this decision, any exit from RUN
    // (w_next_state != RUN) automatically keeps the next cycle pulse-free.
    always_comb begin
        w_pulse_next = 1'b0;
        w_presc_next = '0;
        Mode         = r_state;
        if (w_next_state == c_ST_STEP) begin
            w_pulse_next = (r_state != c_ST_STEP);
        end else if (w_next_state == c_ST_RUN) begin
            if (r_state != c_ST_RUN) begin
                // First RUN cycle always carries a pulse; prescaler restarts.
                w_pulse_next = 1'b1;
                w_presc_next = '0;
            end else begin
                w_pulse_next = (r_presc == c_PRESC_LAST);
                w_presc_next = (r_presc == c_PRESC_LAST) ? '0
                                                          : (r_presc + c_PRESC_W'(1));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------

    // Registered enable, prescaler, issued flag and saturating pulse counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_proc_enable <= 1'b0;
            r_presc       <= '0;
            r_issued      <= 1'b0;
            r_count       <= '0;
        end else begin
            r_proc_enable <= w_pulse_next;
            r_presc       <= w_presc_next;
            if (w_next_state != c_ST_RUN) begin
                r_issued <= 1'b0;
            end else if ((r_state == c_ST_RUN) && r_proc_enable) begin
                r_issued <= 1'b1;
            end
            if (w_pulse_next && (r_count != {CNT_WIDTH{1'b1}})) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign ProcEnable = r_proc_enable;
    assign CycleCount = r_count;

endmodule

`default_nettype wire
